// File: rtl/vram_arbiter.sv
// Shares the single PVR VRAM port between the SH4 CS1 path and the PVR engine.
// PVR is favoured, bounded by PVR_BURST. Optional ack timeout: VRAM_ARB_TIMEOUT_EN.
module vram_arbiter #(
  parameter int unsigned PVR_BURST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [23:0] i_cpu_addr,
  input  logic [63:0] i_cpu_wdata,
  output logic [63:0] o_cpu_rdata,
  output logic        o_cpu_ack,
  input  logic        i_pvr_req,
  input  logic        i_pvr_we,
  input  logic [23:0] i_pvr_addr,
  input  logic [63:0] i_pvr_wdata,
  output logic [63:0] o_pvr_rdata,
  output logic        o_pvr_ack,
  output logic        o_vram_rd,
  output logic        o_vram_wr,
  output logic [23:0] o_vram_addr,
  output logic [63:0] o_vram_dout,
  input  logic [63:0] i_vram_din,
  input  logic        i_vram_ack,
  output logic        o_err
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = $clog2(PVR_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU_XFER, S_PVR_XFER, S_DONE} state_t;

  state_t          r_state, w_state;
  logic            r_we, w_we;
  logic [AW-4:0]   r_addr, w_addr;
  logic [DW-1:0]   r_wdata, w_wdata;
  logic            r_rd, w_rd, r_wr, w_wr;
  logic            r_cpu_ack, w_cpu_ack, r_pvr_ack, w_pvr_ack;
  logic [DW-1:0]   r_cpu_rdata, w_cpu_rdata, r_pvr_rdata, w_pvr_rdata;
  logic [BW-1:0]   r_burst, w_burst;
  logic            w_fin;
  logic [DW-1:0]   w_fin_data;

`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] TMO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  logic [TW-1:0] r_wait, w_wait;
  logic          r_err, w_err;
  assign o_err = r_err;
`else
  // TIMEOUT has no effect in this build
  assign o_err = 1'b0 & (TIMEOUT == 32'd0);
`endif

  // Byte-lane address bits are dropped by the 64-bit VRAM port
  logic w_unused;
  assign w_unused = ^{i_cpu_addr[2:0], i_pvr_addr[2:0]};

  assign o_vram_rd   = r_rd;
  assign o_vram_wr   = r_wr;
  assign o_vram_addr = {r_addr, 3'b000};
  assign o_vram_dout = r_wdata;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_pvr_rdata = r_pvr_rdata;
  assign o_pvr_ack   = r_pvr_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_pvr_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_pvr_rdata <= '0;
      r_burst     <= '0;
`ifdef VRAM_ARB_TIMEOUT_EN
      r_wait      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_rd        <= w_rd;
      r_wr        <= w_wr;
      r_cpu_ack   <= w_cpu_ack;
      r_pvr_ack   <= w_pvr_ack;
      r_cpu_rdata <= w_cpu_rdata;
      r_pvr_rdata <= w_pvr_rdata;
      r_burst     <= w_burst;
`ifdef VRAM_ARB_TIMEOUT_EN
      r_wait      <= w_wait;
      r_err       <= w_err;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_rd        = r_rd;
    w_wr        = r_wr;
    w_cpu_ack   = 1'b0;
    w_pvr_ack   = 1'b0;
    w_cpu_rdata = r_cpu_rdata;
    w_pvr_rdata = r_pvr_rdata;
    w_burst     = r_burst;
    w_fin       = 1'b0;
    w_fin_data  = i_vram_din;
`ifdef VRAM_ARB_TIMEOUT_EN
    w_wait      = r_wait;
    w_err       = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        // PVR wins unless the CPU has waited out a full burst
        if (i_pvr_req && (!i_cpu_req || (r_burst < BW'(PVR_BURST)))) begin
          w_state = S_PVR_XFER;
          w_we    = i_pvr_we;
          w_addr  = i_pvr_addr[AW-1:3];
          w_wdata = i_pvr_wdata;
          w_rd    = !i_pvr_we;
          w_wr    = i_pvr_we;
          w_burst = i_cpu_req ? (r_burst + BW'(1)) : '0;
        end else if (i_cpu_req) begin
          w_state = S_CPU_XFER;
          w_we    = i_cpu_we;
          w_addr  = i_cpu_addr[AW-1:3];
          w_wdata = i_cpu_wdata;
          w_rd    = !i_cpu_we;
          w_wr    = i_cpu_we;
          w_burst = '0;
        end else begin
          w_burst = '0;
        end
`ifdef VRAM_ARB_TIMEOUT_EN
        w_wait = '0;
`endif
      end
      S_CPU_XFER, S_PVR_XFER: begin
        if (i_vram_ack) begin
          w_fin = 1'b1;
`ifdef VRAM_ARB_TIMEOUT_EN
        end else if (r_wait == TW'(TIMEOUT - 1)) begin
          w_fin      = 1'b1;
          w_fin_data = TMO_DATA;
          w_err      = 1'b1;
        end else begin
          w_wait = r_wait + TW'(1);
`endif
        end
      end
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Close the transfer: drop strobe, capture read data, ack the owner
    if (w_fin) begin
      w_state = S_DONE;
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      if (r_state == S_CPU_XFER) begin
        w_cpu_ack = 1'b1;
        if (!r_we) w_cpu_rdata = w_fin_data;
      end else begin
        w_pvr_ack = 1'b1;
        if (!r_we) w_pvr_rdata = w_fin_data;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: cycle table plus burst, back-to-back,
// and (with VRAM_ARB_TIMEOUT_EN) timeout sequences.
module tb_vram_arbiter;

  localparam int unsigned PB  = 4;
  localparam int unsigned TMO = 8;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] WA = 64'hA5A5_A5A5_A5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, pvr_req, pvr_we;
  logic [23:0] cpu_addr, pvr_addr;
  logic [63:0] cpu_wdata, pvr_wdata, cpu_rdata, pvr_rdata;
  logic        cpu_ack, pvr_ack;
  logic        vram_rd, vram_wr, vram_ack, err;
  logic [23:0] vram_addr;
  logic [63:0] vram_dout, vram_din;

  vram_arbiter #(.PVR_BURST(PB), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
    .i_pvr_req(pvr_req), .i_pvr_we(pvr_we), .i_pvr_addr(pvr_addr),
    .i_pvr_wdata(pvr_wdata), .o_pvr_rdata(pvr_rdata), .o_pvr_ack(pvr_ack),
    .o_vram_rd(vram_rd), .o_vram_wr(vram_wr), .o_vram_addr(vram_addr),
    .o_vram_dout(vram_dout), .i_vram_din(vram_din), .i_vram_ack(vram_ack),
    .o_err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // in = {rst, cpu_req, cpu_we, pvr_req, pvr_we, vram_ack}; ctl = {rd, wr, cpu_ack, pvr_ack}
  typedef struct {
    logic [5:0]  in;
    logic [63:0] din;
    logic [3:0]  ctl;
    logic [23:0] addr;
    logic [63:0] crd;
    logic [63:0] prd;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [63:0] din, input logic [3:0] ctl,
                              input logic [23:0] addr, input logic [63:0] crd, input logic [63:0] prd);
    vec_t v;
    v.in = in; v.din = din; v.ctl = ctl; v.addr = addr; v.crd = crd; v.prd = prd;
    return v;
  endfunction

  task automatic drive(input logic [5:0] in, input logic [63:0] din);
    @(negedge clk);
    {rst, cpu_req, cpu_we, pvr_req, pvr_we, vram_ack} = in;
    vram_din = din;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[16];
  bit   exp_p[10];

  initial begin
    int n, viol, rd_cnt, ack_at;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; pvr_req = 0; pvr_we = 0; vram_ack = 0;
    cpu_addr = 24'h000105; pvr_addr = 24'h00A20F;
    cpu_wdata = 64'h1111_2222_3333_4444; pvr_wdata = WA; vram_din = D0;

    vt[0]  = mk(6'b100000, D0, 4'b0000, 24'h000000, 64'h0, 64'h0);
    vt[1]  = mk(6'b010000, D0, 4'b1000, 24'h000100, 64'h0, 64'h0);
    vt[2]  = mk(6'b010000, D0, 4'b1000, 24'h000100, 64'h0, 64'h0);
    vt[3]  = mk(6'b010000, D0, 4'b1000, 24'h000100, 64'h0, 64'h0);
    vt[4]  = mk(6'b010001, D0, 4'b0010, 24'h000100, D0,    64'h0);
    vt[5]  = mk(6'b000000, D0, 4'b0000, 24'h000100, D0,    64'h0);
    vt[6]  = mk(6'b000001, D1, 4'b0000, 24'h000100, D0,    64'h0);
    vt[7]  = mk(6'b000110, D0, 4'b0100, 24'h00A208, D0,    64'h0);
    vt[8]  = mk(6'b000111, D1, 4'b0001, 24'h00A208, D0,    64'h0);
    vt[9]  = mk(6'b000000, D0, 4'b0000, 24'h00A208, D0,    64'h0);
    vt[10] = mk(6'b011100, D0, 4'b1000, 24'h00A208, D0,    64'h0);
    vt[11] = mk(6'b011101, D1, 4'b0001, 24'h00A208, D0,    D1);
    vt[12] = mk(6'b011100, D0, 4'b0000, 24'h00A208, D0,    D1);
    vt[13] = mk(6'b011000, D0, 4'b0100, 24'h000100, D0,    D1);
    vt[14] = mk(6'b111000, D0, 4'b0000, 24'h000000, 64'h0, 64'h0);
    vt[15] = mk(6'b000000, D0, 4'b0000, 24'h000000, 64'h0, 64'h0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].in, vt[i].din);
      tick();
      chk($sformatf("v%0d ctl", i), 64'({vram_rd, vram_wr, cpu_ack, pvr_ack}), 64'(vt[i].ctl));
      chk($sformatf("v%0d addr", i), 64'(vram_addr), 64'(vt[i].addr));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].crd);
      chk($sformatf("v%0d pvr_rdata", i), pvr_rdata, vt[i].prd);
      if (i == 7) chk("pvr write dout", vram_dout, WA);
      if (i == 0 || i == 14) chk($sformatf("v%0d err", i), 64'(err), 64'h0);
    end

    // Both requesters held, memory acks immediately: PVR x4 then CPU
    exp_p = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    drive(6'b100000, D0);
    tick();
    drive(6'b010101, D0);
    n = 0; viol = 0;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      tick();
      if ((cpu_ack && pvr_ack) || (vram_rd && vram_wr) || ((cpu_ack || pvr_ack) && (vram_rd || vram_wr)))
        viol++;
      if (cpu_ack || pvr_ack) begin
        chk($sformatf("grant %0d is pvr", n), 64'(pvr_ack), 64'(exp_p[n]));
        n++;
      end
    end
    chk("burst grants seen", 64'(n), 64'd10);
    chk("burst exclusivity violations", 64'(viol), 64'd0);

    // Back-to-back CPU reads, L = 0: strobe every third cycle
    drive(6'b100000, D0);
    tick();
    drive(6'b010001, D1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("b2b cycle %0d", k), 64'({vram_rd, cpu_ack}),
          64'({(k % 3) == 1, (k % 3) == 2}));
    end
    chk("b2b rdata", cpu_rdata, D1);

`ifdef VRAM_ARB_TIMEOUT_EN
    // Memory never acks a CPU read
    drive(6'b100000, D0);
    tick();
    drive(6'b010000, D0);
    rd_cnt = 0; ack_at = 0;
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      tick();
      if (vram_rd) rd_cnt++;
      if (cpu_ack) begin
        ack_at = k;
        chk("timeout rdata", cpu_rdata, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("timeout err", 64'(err), 64'h1);
      end
    end
    chk("timeout strobe cycles", 64'(rd_cnt), 64'(TMO));
    chk("timeout ack cycle", 64'(ack_at), 64'(TMO + 1));
    drive(6'b000000, D0);
    for (int k = 0; k < 5; k++) tick();
    chk("err sticky", 64'(err), 64'h1);
`else
    rd_cnt = 0; ack_at = 0;
    chk("err tied low", 64'(err), 64'(rd_cnt + ack_at));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-port arbiter that shares the single PVR VRAM port (`vram_rd`/`vram_wr`/`vram_addr`/`vram_din`/`vram_dout`) between the SH4 CS1 path (direct VRAM reads/writes) and the PVR internal engine (renderer/display fetch). It sits between `simtop` address decoding and the external VRAM model. It serialises accesses and grants one requester at a time. PVR is favoured, but a bounded burst limit guarantees the CPU forward progress.

## Interface
- `PVR_BURST`, default 4: maximum back-to-back PVR grants while `cpu_req` is pending.
- `TIMEOUT`, default 255: cycles to wait for `vram_ack` before aborting. Used only with the timeout feature enabled.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous reset, active-high.
- `cpu_req`, in, 1: CPU request. Level signal, held with stable fields until `cpu_ack`.
- `cpu_we`, in, 1: 1 = write, 0 = read.
- `cpu_addr`, in, 24: VRAM byte address; bits [2:0] are ignored.
- `cpu_wdata`, in, 64: write data.
- `cpu_rdata`, out, 64: read data, valid while `cpu_ack` = 1.
- `cpu_ack`, out, 1: one-cycle completion pulse.
- `pvr_req`, `pvr_we`, `pvr_addr`, `pvr_wdata`, `pvr_rdata`, `pvr_ack`: same widths and rules as the CPU port.
- `vram_rd`, out, 1: memory read strobe, held until `vram_ack`.
- `vram_wr`, out, 1: memory write strobe, held until `vram_ack`.
- `vram_addr`, out, 24: memory address, {addr[23:3], 3'b000}.
- `vram_dout`, out, 64: memory write data.
- `vram_din`, in, 64: memory read data, valid with `vram_ack`.
- `vram_ack`, in, 1: memory completion, one cycle.
- `err`, out, 1: sticky timeout flag. Tied to 0 when the timeout feature is compiled out.

## Operation
- States:
  - IDLE: arbitrate.
  - CPU_XFER, PVR_XFER: strobe held, waiting for `vram_ack`.
  - DONE: ack the owner and release.
- Arbitration in IDLE:
  - Only one requester active: grant it.
  - Both active: grant PVR while `burst_cnt` < `PVR_BURST`, otherwise grant CPU.
- `burst_cnt`:
  - Increments on each PVR grant made while `cpu_req` = 1.
  - Clears on any CPU grant, or on an IDLE cycle with `cpu_req` = 0.
  - Saturates at `PVR_BURST`.
- On grant, the owner's `we`/`addr`/`wdata` are latched into registers. The `vram_*` outputs are driven only from these registers, so requester fields may change after their ack.
- XFER:
  - Hold exactly one of `vram_rd`/`vram_wr` (per latched `we`).
  - On `vram_ack`: latch `vram_din` into the owner's rdata register and go to DONE.
- DONE: pulse the owner's `ack` for one cycle, then return to IDLE.
- A `vram_ack` received outside XFER is ignored.
- `cpu_rdata`/`pvr_rdata` hold their last value between transfers. Write transfers leave them unchanged.
- A requester that drops `req` mid-transfer does not abort the transfer; its ack is still issued.

## Timing
- Reset values: state = IDLE, all strobes/acks = 0, `vram_addr` = 0, `vram_dout` = 0, rdata = 0, `burst_cnt` = 0, `err` = 0.
- Reset asserted mid-transfer: the strobe drops on the next edge and no ack is issued.
- With `req` seen in IDLE at cycle T:
  - strobe is high from T+1;
  - `vram_ack` arrives at T+1+L (L ≥ 0 wait cycles);
  - `ack` is high at T+2+L;
  - IDLE is re-entered at T+3+L.
- Minimum transfer period is 3 cycles per access (L = 0).
- `ack` of one requester never coincides with the strobe of the next transfer.
- At most one of `cpu_ack`/`pvr_ack`, and one of `vram_rd`/`vram_wr`, is ever high.

## Configuration
- Macro: `VRAM_ARB_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entering XFER and increments every XFER cycle.
  - When the count reaches `TIMEOUT` without `vram_ack`: drop the strobe, go to DONE, return rdata = 64'hDEAD_BEEF_DEAD_BEEF to a read owner, ack normally, and set `err`.
  - `err` clears only on `rst`.
- Undefined: no counter; XFER waits indefinitely; `err` is constant 0.

## Test plan
- CPU read, L = 2, `vram_din` = 64'h0123_4567_89AB_CDEF, `cpu_addr` = 24'h000105 → `vram_addr` = 24'h000100 held for 3 cycles; `cpu_ack` pulses once with that data 4 cycles after req.
- PVR write, `pvr_wdata` = 64'hA5A5…: `vram_wr` high, `vram_dout` matches, `vram_rd` stays 0; `pvr_rdata` unchanged.
- Both requesters held continuously, `PVR_BURST` = 4, L = 0 → grant order PVR, PVR, PVR, PVR, CPU, PVR×4, CPU…; never more than 4 consecutive PVR grants.
- Spurious `vram_ack` in IDLE, then `rst` asserted during XFER → no ack issued; all outputs equal reset values one cycle later.
- With `VRAM_ARB_TIMEOUT_EN`, `TIMEOUT` = 8, memory never acks a CPU read → strobe drops after 8 XFER cycles; `cpu_rdata` = 64'hDEAD_BEEF_DEAD_BEEF with `cpu_ack`; `err` = 1 and stays 1.
- Back-to-back CPU requests, L = 0 → strobe asserts every 3rd cycle; `cpu_ack` never overlaps a strobe.
